// File: rtl/ddr_cmd_issuer.sv
// DDR4 command issue stage: timing-checked request acceptance, open-bank tracking, registered C/A pins.
// Optional feature macro: AUTO_PRECHARGE_EN (RD/WR auto-precharge through req_ap).
module ddr_cmd_issuer #(
  parameter int unsigned T_RCD = 4,
  parameter int unsigned T_RP  = 4,
  parameter int unsigned T_CCD = 4,
  parameter int unsigned T_RFC = 16
) (
  input  logic        CK_t,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [16:0] req_row,
  input  logic [9:0]  req_col,
  input  logic        req_ap,
  output logic        cs_n,
  output logic        act_n,
  output logic        RAS_n_A16,
  output logic        CAS_n_A15,
  output logic        WE_n_A14,
  output logic        A13,
  output logic        A12_BC_n,
  output logic        A11,
  output logic        A10_AP,
  output logic [9:0]  A9_A0,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic        cmd_rdy,
  output logic        cmd_err
);

  localparam int unsigned CNT_W = $clog2(T_RFC + T_CCD + T_RP + T_RCD) + 1;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef struct packed {
    logic       cs_n;
    logic       act_n;
    logic       ras_n;
    logic       cas_n;
    logic       we_n;
    logic       a13;
    logic       a12;
    logic       a11;
    logic       a10;
    logic [9:0] a9_0;
    logic [1:0] bg;
    logic [1:0] ba;
  } pins_t;

  localparam pins_t PINS_NOP = pins_t'({5'b11111, 18'd0});

  pins_t            r_pins;
  logic             r_cmd_rdy;
  logic             r_cmd_err;
  logic [CNT_W-1:0] r_rcd_cnt;
  logic [CNT_W-1:0] r_rp_cnt;
  logic [CNT_W-1:0] r_ccd_cnt;
  logic [CNT_W-1:0] r_rfc_cnt;
  logic [15:0]      r_open;

  pins_t            w_pins_nxt;
  logic             w_rdy_nxt;
  logic             w_err_nxt;
  logic [CNT_W-1:0] w_rcd_nxt;
  logic [CNT_W-1:0] w_rp_nxt;
  logic [CNT_W-1:0] w_ccd_nxt;
  logic [CNT_W-1:0] w_rfc_nxt;
  logic [15:0]      w_open_nxt;
  logic [3:0]       w_bank;
  logic             w_bank_open;
  logic             w_timing_ok;
  logic             w_accept;
  logic             w_ap;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

`ifdef AUTO_PRECHARGE_EN
  assign w_ap = req_ap;
`else
  logic w_unused_ap;
  assign w_unused_ap = req_ap;
  assign w_ap        = 1'b0;
`endif

  assign w_bank      = {req_bg, req_ba};
  assign w_bank_open = r_open[w_bank];

  // Spacing rule for the command currently presented
  always_comb begin
    w_timing_ok = 1'b1;
    case (req_cmd)
      CMD_ACT, CMD_REF: w_timing_ok = (r_rp_cnt == '0);
      CMD_RD, CMD_WR:   w_timing_ok = (r_rcd_cnt == '0) && (r_ccd_cnt == '0);
      default:          w_timing_ok = 1'b1;
    endcase
  end

  assign req_ready = reset_n && (r_rfc_cnt == '0) && w_timing_ok;
  assign w_accept  = req_valid && req_ready;

  // Decode the accepted request into next pin state, counter loads and bank updates
  always_comb begin
    w_pins_nxt = PINS_NOP;
    w_rdy_nxt  = 1'b0;
    w_err_nxt  = 1'b0;
    w_rcd_nxt  = sat_dec(r_rcd_cnt);
    w_rp_nxt   = sat_dec(r_rp_cnt);
    w_ccd_nxt  = sat_dec(r_ccd_cnt);
    w_rfc_nxt  = sat_dec(r_rfc_cnt);
    w_open_nxt = r_open;
    if (w_accept) begin
      case (req_cmd)
        CMD_NOP: w_err_nxt = 1'b0;
        CMD_ACT: begin
          if (w_bank_open) begin
            w_err_nxt = 1'b1;
          end else begin
            w_pins_nxt.cs_n   = 1'b0;
            w_pins_nxt.act_n  = 1'b0;
            w_pins_nxt.ras_n  = req_row[16];
            w_pins_nxt.cas_n  = req_row[15];
            w_pins_nxt.we_n   = req_row[14];
            w_pins_nxt.a13    = req_row[13];
            w_pins_nxt.a12    = req_row[12];
            w_pins_nxt.a11    = req_row[11];
            w_pins_nxt.a10    = req_row[10];
            w_pins_nxt.a9_0   = req_row[9:0];
            w_pins_nxt.bg     = req_bg;
            w_pins_nxt.ba     = req_ba;
            w_rdy_nxt         = 1'b1;
            w_open_nxt[w_bank] = 1'b1;
            w_rcd_nxt         = CNT_W'(T_RCD - 1);
          end
        end
        CMD_RD, CMD_WR: begin
          if (!w_bank_open) begin
            w_err_nxt = 1'b1;
          end else begin
            w_pins_nxt.cs_n  = 1'b0;
            w_pins_nxt.ras_n = 1'b1;
            w_pins_nxt.cas_n = 1'b0;
            w_pins_nxt.we_n  = (req_cmd == CMD_RD);
            w_pins_nxt.a12   = 1'b1;
            w_pins_nxt.a10   = w_ap;
            w_pins_nxt.a9_0  = req_col;
            w_pins_nxt.bg    = req_bg;
            w_pins_nxt.ba    = req_ba;
            w_rdy_nxt        = 1'b1;
            w_ccd_nxt        = CNT_W'(T_CCD - 1);
            // Implicit precharge closes the bank and holds off the next ACT
            if (w_ap) begin
              w_open_nxt[w_bank] = 1'b0;
              w_rp_nxt           = CNT_W'(T_CCD + T_RP - 1);
            end
          end
        end
        CMD_PRE: begin
          w_pins_nxt.cs_n    = 1'b0;
          w_pins_nxt.ras_n   = 1'b0;
          w_pins_nxt.we_n    = 1'b0;
          w_pins_nxt.bg      = req_bg;
          w_pins_nxt.ba      = req_ba;
          w_rdy_nxt          = 1'b1;
          w_open_nxt[w_bank] = 1'b0;
          w_rp_nxt           = CNT_W'(T_RP - 1);
        end
        CMD_REF: begin
          if (r_open != '0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_pins_nxt.cs_n  = 1'b0;
            w_pins_nxt.ras_n = 1'b0;
            w_pins_nxt.cas_n = 1'b0;
            w_rdy_nxt        = 1'b1;
            w_rfc_nxt        = CNT_W'(T_RFC - 1);
          end
        end
        default: w_err_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_pins    <= PINS_NOP;
      r_cmd_rdy <= 1'b0;
      r_cmd_err <= 1'b0;
      r_rcd_cnt <= '0;
      r_rp_cnt  <= '0;
      r_ccd_cnt <= '0;
      r_rfc_cnt <= '0;
      r_open    <= '0;
    end else begin
      r_pins    <= w_pins_nxt;
      r_cmd_rdy <= w_rdy_nxt;
      r_cmd_err <= w_err_nxt;
      r_rcd_cnt <= w_rcd_nxt;
      r_rp_cnt  <= w_rp_nxt;
      r_ccd_cnt <= w_ccd_nxt;
      r_rfc_cnt <= w_rfc_nxt;
      r_open    <= w_open_nxt;
    end
  end

  assign cs_n      = r_pins.cs_n;
  assign act_n     = r_pins.act_n;
  assign RAS_n_A16 = r_pins.ras_n;
  assign CAS_n_A15 = r_pins.cas_n;
  assign WE_n_A14  = r_pins.we_n;
  assign A13       = r_pins.a13;
  assign A12_BC_n  = r_pins.a12;
  assign A11       = r_pins.a11;
  assign A10_AP    = r_pins.a10;
  assign A9_A0     = r_pins.a9_0;
  assign bg_addr   = r_pins.bg;
  assign ba_addr   = r_pins.ba;
  assign cmd_rdy   = r_cmd_rdy;
  assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Bench for ddr_cmd_issuer: directed scenarios plus randomized traffic against a
// cycle-time reference model (each timing rule kept as "earliest legal issue cycle").
module tb_ddr_cmd_issuer;
  localparam int T_RCD = 4;
  localparam int T_RP  = 4;
  localparam int T_CCD = 4;
  localparam int T_RFC = 16;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;
  localparam logic [4:0] P_NOP = 5'b11111;

`ifdef AUTO_PRECHARGE_EN
  localparam bit AP_EN = 1'b1;
`else
  localparam bit AP_EN = 1'b0;
`endif

  logic        CK_t = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_cmd = 3'd0;
  logic [1:0]  req_bg = 2'd0;
  logic [1:0]  req_ba = 2'd0;
  logic [16:0] req_row = 17'd0;
  logic [9:0]  req_col = 10'd0;
  logic        req_ap = 1'b0;
  logic        req_ready;
  logic        cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic        A13, A12_BC_n, A11, A10_AP;
  logic [9:0]  A9_A0;
  logic [1:0]  bg_addr, ba_addr;
  logic        cmd_rdy, cmd_err;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model: open banks and the first cycle each timing rule allows
  bit [15:0] m_open;
  int m_rcd_free, m_rp_free, m_ccd_free, m_rfc_free;

  ddr_cmd_issuer #(.T_RCD(T_RCD), .T_RP(T_RP), .T_CCD(T_CCD), .T_RFC(T_RFC)) u_dut (
    .CK_t(CK_t), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .req_ap(req_ap), .cs_n(cs_n), .act_n(act_n),
    .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14), .A13(A13),
    .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0),
    .bg_addr(bg_addr), .ba_addr(ba_addr), .cmd_rdy(cmd_rdy), .cmd_err(cmd_err)
  );

  always #5 CK_t = ~CK_t;

  function automatic logic [4:0] pins5();
    return {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14};
  endfunction

  function automatic logic [13:0] addr14();
    return {A13, A12_BC_n, A11, A10_AP, A9_A0};
  endfunction

  task automatic step();
    @(posedge CK_t);
    #1;
    cyc++;
  endtask

  task automatic set_req(input logic v, input logic [2:0] c, input logic [1:0] g,
                         input logic [1:0] a, input logic [16:0] row,
                         input logic [9:0] col, input logic ap);
    req_valid = v; req_cmd = c; req_bg = g; req_ba = a;
    req_row = row; req_col = col; req_ap = ap;
  endtask

  // Count not-ready cycles until ready (bounded); quiet drops if pins leave NOP meanwhile
  task automatic wait_ready(input int bound, output int n, output bit quiet);
    n = 0; quiet = 1'b1;
    #1;
    while (req_ready !== 1'b1 && n < bound) begin
      n++;
      step();
      if (pins5() !== P_NOP || cmd_rdy !== 1'b0) quiet = 1'b0;
      #1;
    end
  endtask

  task automatic model_reset();
    m_open = '0;
    m_rcd_free = 0; m_rp_free = 0; m_ccd_free = 0; m_rfc_free = 0;
  endtask

  function automatic bit m_ready(input logic [2:0] c, input int t);
    if (t < m_rfc_free) return 1'b0;
    case (c)
      C_ACT, C_REF: return t >= m_rp_free;
      C_RD, C_WR:   return (t >= m_rcd_free) && (t >= m_ccd_free);
      default:      return 1'b1;
    endcase
  endfunction

  function automatic bit m_legal(input logic [2:0] c, input logic [3:0] bank);
    case (c)
      C_ACT:      return !m_open[bank];
      C_RD, C_WR: return m_open[bank];
      C_PRE:      return 1'b1;
      C_REF:      return m_open == '0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] m_cmd5(input logic [2:0] c, input logic [16:0] row);
    case (c)
      C_ACT:   return {2'b00, row[16:14]};
      C_RD:    return 5'b01101;
      C_WR:    return 5'b01100;
      C_PRE:   return 5'b01010;
      C_REF:   return 5'b01001;
      default: return P_NOP;
    endcase
  endfunction

  task automatic test_reset();
    set_req(1'b1, C_PRE, 2'd3, 2'd1, 17'h1FFFF, 10'h3FF, 1'b1);
    repeat (3) step();
    n_chk++; if (pins5() !== P_NOP) $display("FAIL rst_pins got %b want %b", pins5(), P_NOP); else n_pass++;
    n_chk++; if ({addr14(), bg_addr, ba_addr} !== 18'd0) $display("FAIL rst_addr got %h want 0", {addr14(), bg_addr, ba_addr}); else n_pass++;
    n_chk++; if ({cmd_rdy, cmd_err} !== 2'b00) $display("FAIL rst_pulses got %b want 00", {cmd_rdy, cmd_err}); else n_pass++;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", req_ready); else n_pass++;
    reset_n = 1'b1;
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", req_ready); else n_pass++;
    set_req(1'b0, C_NOP, 2'd0, 2'd0, 17'd0, 10'd0, 1'b0);
    step();
    n_chk++; if (pins5() !== P_NOP) $display("FAIL rst_idle_pins got %b want %b", pins5(), P_NOP); else n_pass++;
  endtask

  task automatic test_act_rd();
    int n; bit q; int t_act; int pulses;
    logic [16:0] row;
    row = 17'h1ABCD; pulses = 0;
    set_req(1'b1, C_ACT, 2'd1, 2'd2, row, 10'd0, 1'b0);
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL act_ready got %b want 1", req_ready); else n_pass++;
    step(); t_act = cyc;
    if (cmd_rdy === 1'b1) pulses++;
    n_chk++; if (pins5() !== {2'b00, row[16:14]}) $display("FAIL act_pins got %b want %b", pins5(), {2'b00, row[16:14]}); else n_pass++;
    n_chk++; if (addr14() !== row[13:0]) $display("FAIL act_addr got %h want %h", addr14(), row[13:0]); else n_pass++;
    n_chk++; if (A9_A0 !== 10'h3CD) $display("FAIL act_a9a0 got %h want 3cd", A9_A0); else n_pass++;
    n_chk++; if ({bg_addr, ba_addr} !== 4'b0110) $display("FAIL act_bank got %b want 0110", {bg_addr, ba_addr}); else n_pass++;
    set_req(1'b1, C_RD, 2'd1, 2'd2, 17'd0, 10'h155, 1'b0);
    wait_ready(20, n, q);
    n_chk++; if (n !== T_RCD - 1) $display("FAIL rd_wait got %0d want %0d", n, T_RCD - 1); else n_pass++;
    n_chk++; if (q !== 1'b1) $display("FAIL rd_wait_nop got %b want 1", q); else n_pass++;
    step();
    if (cmd_rdy === 1'b1) pulses++;
    n_chk++; if (cyc - t_act !== T_RCD) $display("FAIL rd_latency got %0d want %0d", cyc - t_act, T_RCD); else n_pass++;
    n_chk++; if (pins5() !== 5'b01101) $display("FAIL rd_pins got %b want 01101", pins5()); else n_pass++;
    n_chk++; if (addr14() !== {4'b0100, 10'h155}) $display("FAIL rd_addr got %h want %h", addr14(), {4'b0100, 10'h155}); else n_pass++;
    n_chk++; if (pulses !== 2) $display("FAIL act_rd_pulses got %0d want 2", pulses); else n_pass++;
    set_req(1'b0, C_NOP, 2'd0, 2'd0, 17'd0, 10'd0, 1'b0);
    step();
    n_chk++; if ({pins5(), cmd_rdy} !== {P_NOP, 1'b0}) $display("FAIL rd_after_pins got %b want %b", {pins5(), cmd_rdy}, {P_NOP, 1'b0}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n; bit q; int t1;
    set_req(1'b1, C_WR, 2'd1, 2'd2, 17'd0, 10'h2AA, 1'b0);
    wait_ready(20, n, q);
    n_chk++; if (n >= 20) $display("FAIL wr1_timeout got %0d want <20", n); else n_pass++;
    step(); t1 = cyc;
    n_chk++; if ({pins5(), A9_A0} !== {5'b01100, 10'h2AA}) $display("FAIL wr1_pins got %h want %h", {pins5(), A9_A0}, {5'b01100, 10'h2AA}); else n_pass++;
    set_req(1'b1, C_WR, 2'd1, 2'd2, 17'd0, 10'h0F0, 1'b0);
    wait_ready(20, n, q);
    n_chk++; if (q !== 1'b1) $display("FAIL wr_gap_nop got %b want 1", q); else n_pass++;
    step();
    n_chk++; if (cyc - t1 !== T_CCD) $display("FAIL wr2_spacing got %0d want %0d", cyc - t1, T_CCD); else n_pass++;
    n_chk++; if ({pins5(), A9_A0, cmd_rdy} !== {5'b01100, 10'h0F0, 1'b1}) $display("FAIL wr2_pins got %h want %h", {pins5(), A9_A0, cmd_rdy}, {5'b01100, 10'h0F0, 1'b1}); else n_pass++;
    set_req(1'b0, C_NOP, 2'd0, 2'd0, 17'd0, 10'd0, 1'b0);
    step();
  endtask

  task automatic test_closed_bank();
    repeat (6) step();
    set_req(1'b1, C_RD, 2'd3, 2'd3, 17'd0, 10'h011, 1'b0);
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL closed_rd_ready got %b want 1", req_ready); else n_pass++;
    step();
    n_chk++; if ({pins5(), cmd_rdy, cmd_err} !== {P_NOP, 2'b01}) $display("FAIL closed_rd_err got %b want %b", {pins5(), cmd_rdy, cmd_err}, {P_NOP, 2'b01}); else n_pass++;
    set_req(1'b1, C_RD, 2'd1, 2'd2, 17'd0, 10'h001, 1'b0);
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL closed_ccd_untouched got %b want 1", req_ready); else n_pass++;
    step();
    n_chk++; if ({cmd_rdy, cmd_err} !== 2'b10) $display("FAIL open_rd_issue got %b want 10", {cmd_rdy, cmd_err}); else n_pass++;
    set_req(1'b1, C_ACT, 2'd3, 2'd3, 17'h00042, 10'd0, 1'b0);
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL closed_act_ready got %b want 1", req_ready); else n_pass++;
    step();
    n_chk++; if ({pins5(), cmd_rdy, cmd_err} !== {5'b00000, 2'b10}) $display("FAIL closed_act_issue got %b want %b", {pins5(), cmd_rdy, cmd_err}, {5'b00000, 2'b10}); else n_pass++;
    set_req(1'b0, C_NOP, 2'd0, 2'd0, 17'd0, 10'd0, 1'b0);
    step();
    n_chk++; if ({pins5(), cmd_err} !== {P_NOP, 1'b0}) $display("FAIL closed_idle got %b want %b", {pins5(), cmd_err}, {P_NOP, 1'b0}); else n_pass++;
  endtask

  task automatic test_pre_ref();
    int n; bit q; int t_pre; int t_ref;
    set_req(1'b1, C_PRE, 2'd3, 2'd3, 17'd0, 10'd0, 1'b0);
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL pre_ready got %b want 1", req_ready); else n_pass++;
    step(); t_pre = cyc;
    n_chk++; if ({pins5(), A10_AP} !== 6'b010100) $display("FAIL pre_pins got %b want 010100", {pins5(), A10_AP}); else n_pass++;
    set_req(1'b1, C_ACT, 2'd3, 2'd3, 17'h00777, 10'd0, 1'b0);
    wait_ready(20, n, q);
    step();
    n_chk++; if (cyc - t_pre !== T_RP) $display("FAIL pre_act_spacing got %0d want %0d", cyc - t_pre, T_RP); else n_pass++;
    n_chk++; if ({cmd_rdy, cmd_err} !== 2'b10) $display("FAIL pre_act_issue got %b want 10", {cmd_rdy, cmd_err}); else n_pass++;
    set_req(1'b1, C_PRE, 2'd3, 2'd3, 17'd0, 10'd0, 1'b0);
    step();
    set_req(1'b1, C_PRE, 2'd1, 2'd2, 17'd0, 10'd0, 1'b0);
    step();
    set_req(1'b1, C_REF, 2'd0, 2'd0, 17'd0, 10'd0, 1'b0);
    wait_ready(20, n, q);
    step(); t_ref = cyc;
    n_chk++; if ({pins5(), cmd_rdy, cmd_err} !== {5'b01001, 2'b10}) $display("FAIL ref_pins got %b want %b", {pins5(), cmd_rdy, cmd_err}, {5'b01001, 2'b10}); else n_pass++;
    set_req(1'b0, C_PRE, 2'd0, 2'd0, 17'd0, 10'd0, 1'b0);
    wait_ready(40, n, q);
    n_chk++; if (n !== T_RFC - 1) $display("FAIL ref_busy_cycles got %0d want %0d", n, T_RFC - 1); else n_pass++;
    step();
  endtask

`ifdef AUTO_PRECHARGE_EN
  task automatic test_auto_precharge();
    int n; bit q; int t_wr;
    set_req(1'b1, C_ACT, 2'd2, 2'd0, 17'h00123, 10'd0, 1'b0);
    wait_ready(30, n, q);
    step();
    set_req(1'b1, C_WR, 2'd2, 2'd0, 17'd0, 10'h033, 1'b1);
    wait_ready(30, n, q);
    step(); t_wr = cyc;
    n_chk++; if ({pins5(), A10_AP} !== 6'b011001) $display("FAIL ap_wr_pins got %b want 011001", {pins5(), A10_AP}); else n_pass++;
    set_req(1'b1, C_ACT, 2'd2, 2'd0, 17'h00124, 10'd0, 1'b0);
    wait_ready(30, n, q);
    step();
    n_chk++; if (cyc - t_wr !== T_CCD + T_RP) $display("FAIL ap_act_spacing got %0d want %0d", cyc - t_wr, T_CCD + T_RP); else n_pass++;
    n_chk++; if ({cmd_rdy, cmd_err} !== 2'b10) $display("FAIL ap_act_issue got %b want 10", {cmd_rdy, cmd_err}); else n_pass++;
    set_req(1'b0, C_NOP, 2'd0, 2'd0, 17'd0, 10'd0, 1'b0);
    step();
  endtask
`endif

  task automatic test_reset_mid_act();
    int n; bit q;
    set_req(1'b1, C_ACT, 2'd0, 2'd1, 17'h00005, 10'd0, 1'b0);
    wait_ready(30, n, q);
    step();
    n_chk++; if (cmd_rdy !== 1'b1) $display("FAIL midrst_act_issue got %b want 1", cmd_rdy); else n_pass++;
    #1 reset_n = 1'b0;
    #1;
    n_chk++; if ({pins5(), cmd_rdy, req_ready} !== {P_NOP, 2'b00}) $display("FAIL midrst_pins got %b want %b", {pins5(), cmd_rdy, req_ready}, {P_NOP, 2'b00}); else n_pass++;
    #1 reset_n = 1'b1;
    set_req(1'b1, C_RD, 2'd0, 2'd1, 17'd0, 10'h00A, 1'b0);
    wait_ready(10, n, q);
    n_chk++; if (n !== 0) $display("FAIL midrst_counters got %0d want 0", n); else n_pass++;
    step();
    n_chk++; if ({pins5(), cmd_rdy, cmd_err} !== {P_NOP, 2'b01}) $display("FAIL midrst_rd_err got %b want %b", {pins5(), cmd_rdy, cmd_err}, {P_NOP, 2'b01}); else n_pass++;
    set_req(1'b0, C_NOP, 2'd0, 2'd0, 17'd0, 10'd0, 1'b0);
    step();
  endtask

  task automatic test_random();
    logic [2:0] c; logic [1:0] g, a; logic [16:0] row; logic [9:0] col;
    logic v, ap; bit rdy_e, acc, legal, iss, err; int r;
    logic [13:0] addr_e;
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      c = (r < 25) ? C_ACT : (r < 45) ? C_RD : (r < 60) ? C_WR : (r < 78) ? C_PRE :
          (r < 84) ? C_REF : (r < 92) ? C_NOP : 3'(6 + (r & 1));
      g = 2'($urandom_range(0, 1)); a = 2'($urandom_range(0, 1));
      row = 17'($urandom); col = 10'($urandom); ap = 1'($urandom);
      v = ($urandom_range(0, 99) < 85);
      set_req(v, c, g, a, row, col, ap);
      #1;
      rdy_e = m_ready(c, cyc + 1);
      n_chk++; if (req_ready !== rdy_e) $display("FAIL rnd_ready cyc %0d cmd %0d got %b want %b", cyc, c, req_ready, rdy_e); else n_pass++;
      acc = v && rdy_e;
      legal = m_legal(c, {g, a});
      iss = acc && (c != C_NOP) && legal;
      err = acc && (c != C_NOP) && !legal;
      addr_e = (c == C_ACT) ? row[13:0] : {3'b010, AP_EN && ap, col};
      step();
      n_chk++; if ({cmd_rdy, cmd_err} !== {iss, err}) $display("FAIL rnd_pulses cyc %0d cmd %0d got %b want %b", cyc, c, {cmd_rdy, cmd_err}, {iss, err}); else n_pass++;
      n_chk++; if (pins5() !== (iss ? m_cmd5(c, row) : P_NOP)) $display("FAIL rnd_pins cyc %0d cmd %0d got %b want %b", cyc, c, pins5(), iss ? m_cmd5(c, row) : P_NOP); else n_pass++;
      if (iss && (c == C_ACT || c == C_RD || c == C_WR)) begin
        n_chk++; if ({addr14(), bg_addr, ba_addr} !== {addr_e, g, a}) $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, {addr14(), bg_addr, ba_addr}, {addr_e, g, a}); else n_pass++;
      end
      if (iss) begin
        case (c)
          C_ACT: begin m_open[{g, a}] = 1'b1; m_rcd_free = cyc + T_RCD; end
          C_RD, C_WR: begin
            m_ccd_free = cyc + T_CCD;
            if (AP_EN && ap) begin m_open[{g, a}] = 1'b0; m_rp_free = cyc + T_CCD + T_RP; end
          end
          C_PRE: begin m_open[{g, a}] = 1'b0; m_rp_free = cyc + T_RP; end
          C_REF: m_rfc_free = cyc + T_RFC;
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    test_reset();
    test_act_rd();
    test_back_to_back();
    test_closed_bank();
    test_pre_ref();
`ifdef AUTO_PRECHARGE_EN
    test_auto_precharge();
`endif
    test_reset_mid_act();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
